// File: rtl/tune_pkg.sv
// Shared types and constants for the table-driven tune sequencer.
// Note-table entry layout: {half_period, duration}, with duration in the low bits.
package tune_pkg;

   // Sequencer control states
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      GAP
   } state_t;

   // Default field widths of a note-table entry
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_PERIOD_W = 18;
   localparam int DEF_DUR_W    = 4;

   // Field offsets: duration starts at bit 0 and half_period sits directly above it
   localparam int DUR_LSB = 0;

   // Bit offset of the half_period field for a given duration width
   function automatic int period_lsb(input int dur_w);
      return DUR_LSB + dur_w;
   endfunction

   // Tone half-periods in board clocks
   localparam int HP_C4 = 95786;
   localparam int HP_D4 = 85325;
   localparam int HP_E4 = 75988;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles its output every half_period clocks.
// A half_period of zero is a rest and keeps the output low.
module tone_gen #(
   parameter int PERIOD_W = 18
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] half_period,
   input  logic                clear,
   input  logic                enable,
   output logic                square
);

   logic [PERIOD_W-1:0] cnt;

   // Half-period counter and output phase; clear has priority and zeroes both
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: flops are written with <= so every register samples pre-edge values.
      if (rst) begin
         cnt    <= '0;
         square <= 1'b0;
      end else if (clear) begin
         cnt    <= '0;
         square <= 1'b0;
      end else if (enable && (half_period != '0)) begin
         if (cnt == half_period - PERIOD_W'(1)) begin
            cnt    <= '0;
            square <= ~square;
         end else begin
            cnt <= cnt + PERIOD_W'(1);
         end
      end
   end

endmodule

// File: rtl/tune_sequencer.sv
// Table-driven tune player: fetches {half_period, duration} entries from a
// synchronous ROM, times each note and its trailing silent gap, and drives
// the speaker through tone_gen.
// Optional feature macro: TUNE_SEQ_OCTAVE_EN adds input octave_up, which
// halves the half_period of each note loaded while it is high.
module tune_sequencer
   import tune_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int DUR_W    = DEF_DUR_W,
   parameter int TICK_CYC = 20000000,
   parameter int GAP_CYC  = 2000000
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      loop_en,
   input  logic [ADDR_W-1:0]         last_idx,
`ifdef TUNE_SEQ_OCTAVE_EN
   input  logic                      octave_up,
`endif
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [PERIOD_W+DUR_W-1:0] rom_data,
   output logic                      Music,
   output logic                      busy,
   output logic                      done
);

   // Last tick-counter value of a full tick, and of the sounding part of the last tick
   localparam logic [31:0] TICK_LAST = 32'(TICK_CYC - 1);
   localparam logic [31:0] PLAY_LAST = 32'(TICK_CYC - GAP_CYC - 1);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   addr_next;
   logic                done_next;
   logic [31:0]         tick_cnt, tick_next;
   logic [DUR_W-1:0]    dur_cnt, dur_next;
   logic [PERIOD_W-1:0] hp_q, hp_next;
   logic [DUR_W-1:0]    len_q, len_next;
   logic                end_song;
   logic [PERIOD_W-1:0] entry_hp, load_hp;
   logic [DUR_W-1:0]    entry_dur;
   logic                tone_clear;

   assign entry_dur = rom_data[DUR_LSB +: DUR_W];
   assign entry_hp  = rom_data[period_lsb(DUR_W) +: PERIOD_W];

`ifdef TUNE_SEQ_OCTAVE_EN
   // Octave-up halves the half period but never turns a note into a rest
   always_comb begin
      load_hp = entry_hp;
      if (octave_up && (entry_hp != '0)) begin
         load_hp = entry_hp >> 1;
         if (load_hp == '0) load_hp = PERIOD_W'(1);
      end
   end
`else
   assign load_hp = entry_hp;
`endif

   // State, address, note fields, timing counters and the done pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         rom_addr <= '0;
         done     <= 1'b0;
         tick_cnt <= '0;
         dur_cnt  <= '0;
         hp_q     <= '0;
         len_q    <= '0;
      end else begin
         state    <= state_next;
         rom_addr <= addr_next;
         done     <= done_next;
         tick_cnt <= tick_next;
         dur_cnt  <= dur_next;
         hp_q     <= hp_next;
         len_q    <= len_next;
      end
   end

   // Next-state logic: note timing, address stepping, end-of-song and stop
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_next = state;
      addr_next  = rom_addr;
      done_next  = 1'b0;
      tick_next  = tick_cnt;
      dur_next   = dur_cnt;
      hp_next    = hp_q;
      len_next   = len_q;
      end_song   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               addr_next  = '0;
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            hp_next   = load_hp;
            len_next  = entry_dur;
            tick_next = '0;
            dur_next  = '0;
            if (entry_dur == '0) end_song = 1'b1;
            else                 state_next = PLAY;
         end
         PLAY: begin
            if (tick_cnt == TICK_LAST) begin
               tick_next = '0;
               dur_next  = dur_cnt + DUR_W'(1);
            end else begin
               tick_next = tick_cnt + 32'd1;
            end
            // The gap takes the tail of the final tick
            if ((dur_cnt == len_q - DUR_W'(1)) && (tick_cnt == PLAY_LAST))
               state_next = GAP;
         end
         GAP: begin
            tick_next = tick_cnt + 32'd1;
            if (tick_cnt == TICK_LAST) begin
               if (rom_addr == last_idx) begin
                  end_song = 1'b1;
               end else begin
                  addr_next  = rom_addr + ADDR_W'(1);
                  state_next = FETCH;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (end_song) begin
         addr_next = '0;
         if (loop_en) begin
            state_next = FETCH;
         end else begin
            state_next = IDLE;
            done_next  = 1'b1;
         end
      end

      if (stop) begin
         state_next = IDLE;
         addr_next  = '0;
         done_next  = 1'b0;
         tick_next  = '0;
         dur_next   = '0;
      end
   end

   // Tone runs only while staying in PLAY; any other edge zeroes the phase
   assign tone_clear = !((state == PLAY) && (state_next == PLAY));
   assign busy       = (state != IDLE);

   tone_gen #(
      .PERIOD_W(PERIOD_W)
   ) u_tone (
      .clk        (CLK),
      .rst        (RST),
      .half_period(hp_q),
      .clear      (tone_clear),
      .enable     (state == PLAY),
      .square     (Music)
   );

endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
Plays a song held in an external note table. It fetches one entry at a time through a synchronous ROM port and times each note's duration and silent articulation gap. It also generates that note's square-wave tone on the speaker output. It sits between the board's control logic (play/stop/loop) and the speaker pin. It replaces hard-coded per-song note masks with a table-driven scheduler that serves any song.

Parameters:
ADDR_W, 5, note-table address width (max 2^ADDR_W entries)
PERIOD_W, 18, width of tone half-period field in clocks
DUR_W, 4, width of duration field in ticks
TICK_CYC, 20000000, clocks per duration tick
GAP_CYC, 2000000, silent clocks at end of every note; must satisfy 0 < GAP_CYC < TICK_CYC

Ports:
CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse: begin playback at entry 0
stop  in  1  one-cycle pulse: abort playback
loop_en  in  1  restart at entry 0 after the last entry
last_idx  in  ADDR_W  index of final entry in song
rom_addr  out  ADDR_W  note-table address
rom_data  in  PERIOD_W+DUR_W  {half_period, duration}; valid 1 cycle after rom_addr
Music  out  1  speaker square wave
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the song ends without a loop

Behaviour:
- Reset (async): state=IDLE, rom_addr=0, Music=0, busy=0, done=0; all counters and tone phase 0.
- Entry: half_period (upper PERIOD_W bits), duration (lower DUR_W bits).
  - half_period=0: rest (Music held 0 for the whole note).
  - duration=0: end-of-song marker; nothing is played.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: on start (and no stop) -> FETCH with rom_addr=0.
- FETCH: one cycle, waits out ROM latency -> LOAD.
- LOAD: capture rom_data.
  - duration=0 -> end handling.
  - Otherwise -> PLAY; clear tick and duration counters; tone phase=0; tone counter=0.
- PLAY:
  - Lasts exactly duration*TICK_CYC-GAP_CYC clocks, then -> GAP.
  - Music=tone. Tone toggles when tone counter reaches half_period-1; the counter then wraps to 0.
- GAP: GAP_CYC clocks with Music=0, then:
  - rom_addr==last_idx -> end handling.
  - Otherwise rom_addr+1 -> FETCH.
- End handling:
  - loop_en=1: rom_addr=0 -> FETCH; no done pulse.
  - loop_en=0: done=1 for one cycle -> IDLE; rom_addr=0.
- rom_addr wraps 2^ADDR_W-1 -> 0 naturally if last_idx is never matched.
- Music is registered and is 0 in every state except PLAY.
- stop: from any state -> IDLE on the next clock; Music=0, rom_addr=0, no done pulse.
- stop and start in the same cycle: stop wins.
- start while busy: ignored.
- last_idx and loop_en are sampled at end handling; changes mid-note are legal.
- Counter arithmetic: duration counter is DUR_W bits; tick counter is 32 bits; tone counter is PERIOD_W bits. No overflow is possible within the legal ranges.

Optional Feature:
Macro TUNE_SEQ_OCTAVE_EN.
- Defined: adds input octave_up (1 bit), sampled in LOAD. When 1, the effective half_period = half_period>>1, forced to a minimum of 1 if the original was nonzero; rests stay rests.
- Undefined: port absent; half_period is used unmodified.

Decomposition:
- Package tune_pkg holds:
  - state enum {IDLE, FETCH, LOAD, PLAY, GAP}
  - note-entry field offsets and widths
  - named half-period constants for C4/D4/E4 at the board clock: 95786, 85325, 75988
- Sub-module tone_gen (half_period in, phase clear, enable, square out) is natural and reused. The duration/gap timing stays in the top.

Test Plan (bench params TICK_CYC=10, GAP_CYC=2, PERIOD_W=8):
- Reset mid-PLAY: assert RST asynchronously -> Music, busy and rom_addr read 0 immediately, without waiting for a clock edge.
- Single note {half_period=3, duration=2}, last_idx=0, loop_en=0, pulse start:
  - rom_addr=0, then 18 PLAY clocks with Music toggling every 3 clocks
  - then 2 clocks of Music=0
  - then done high for exactly 1 cycle; busy low.
- Three entries (rest dur=1; note hp=2 dur=1; terminator dur=0), last_idx=7:
  - first entry: 8 clocks of Music=0 (rest), then 2 gap clocks
  - then the note plays
  - playback ends at entry 2 with a done pulse; rom_addr never exceeds 2.
- loop_en=1, last_idx=1: after entry 1's GAP, rom_addr returns to 0 with no done pulse. Deassert loop_en during the second pass -> done after the next entry 1.
- Pulse stop in PLAY cycle 5 -> IDLE next clock, Music=0, no done. start and stop in the same cycle from IDLE -> stays IDLE.
- With TUNE_SEQ_OCTAVE_EN, octave_up=1, hp=3 -> Music toggles every 1 clock; hp=0 -> still silent.
